pixel_reorder_buffer: RTL

Parametrised reorder stage that accepts tagged pixels (data plus sequence address) arriving out of order from parallel render/fetch lanes and emits them strictly in ascending address order. It sits between the multi-lane pixel generators and the frame-buffer writer.
Compared with the earlier sort stage, it adds:
- generic data, address and depth widths
- an output valid/ready handshake
- explicit window and duplicate error detection
- an occupancy count
- an optional skip-on-timeout mode so that one lost pixel cannot stall a frame

---
 rtl/pixel_reorder_pkg.sv | 12 +
 rtl/pixel_reorder_mem.sv | 20 ++
 rtl/pixel_reorder_buffer.sv | 98 +++++++++
 3 files changed

// File: rtl/pixel_reorder_pkg.sv
// pixel_reorder_pkg: shared widths and window check for the pixel reorder stage
// Defaults match the pixel pipeline (24-bit RGB, 20-bit sequence address, 16-entry window).
package pixel_reorder_pkg;
    localparam int PIX_DW = 24;
    localparam int PIX_AW = 20;
    localparam int PIX_DEPTH = 16;
    localparam int PIX_IDXW = $clog2(PIX_DEPTH);
    // diff is the modular distance (addr - seq) zero-extended; wrap is absorbed by the subtraction
    function automatic logic in_window(input logic [63:0] diff, input int depth);
        return diff < 64'(depth);
    endfunction
endpackage

// File: rtl/pixel_reorder_mem.sv
// pixel_reorder_mem: DEPTH x DW slot storage, one synchronous write port, one combinational read port
// Ports: clk; we/waddr/wdata write a slot on the clock edge; raddr/rdata read a slot combinationally.
module pixel_reorder_mem
    import pixel_reorder_pkg::*;
#(
    parameter int DW = PIX_DW,
    parameter int DEPTH = PIX_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/pixel_reorder_buffer.sv
// pixel_reorder_buffer: reorders tagged out-of-order pixels into ascending sequence-address order
// Ports: clk, rst_n (async, active-low); in_data/in_addr/in_valid/in_vs tagged input, no backpressure;
// out_data/out_addr/out_valid/out_ready/out_skipped ordered output with handshake; out_vs delayed in_vs;
// err_window/err_dup one-cycle drop pulses; occupancy count of stored slots.
module pixel_reorder_buffer
    import pixel_reorder_pkg::*;
#(
    parameter int            DW = PIX_DW,
    parameter int            AW = PIX_AW,
    parameter int            DEPTH = PIX_DEPTH,
    parameter int            TIMEOUT = 0,
    parameter logic [DW-1:0] FILL = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DW-1:0]          in_data,
    input  logic [AW-1:0]          in_addr,
    input  logic                   in_valid,
    input  logic                   in_vs,
    output logic [DW-1:0]          out_data,
    output logic [AW-1:0]          out_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_skipped,
    output logic                   out_vs,
    output logic                   err_window,
    output logic                   err_dup,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int IDXW = $clog2(DEPTH);
    localparam int OW = IDXW + 1;
    logic [AW-1:0] seq, eseq, diff;
    logic [DEPTH-1:0] flags, flags_eff, flags_nxt;
    logic [IDXW-1:0] slot, head;
    logic [DW-1:0] head_data;
    logic [31:0] to_cnt, to_nxt;
    logic [OW-1:0] pop;
    logic load, win, hit, head_st, byp, fill, emit, store;
    // Frame start acts within the same cycle: flags and seq are seen as cleared before evaluating the input.
    always_comb begin
        eseq = in_vs ? '0 : seq;
        flags_eff = in_vs ? '0 : flags;
        diff = in_addr - eseq;
        win = in_window(64'(diff), DEPTH);
        slot = in_addr[IDXW-1:0];
        head = eseq[IDXW-1:0];
        hit = flags_eff[slot];
        load = !out_valid || out_ready;
        head_st = flags_eff[head];
        byp = load && !head_st && in_valid && (in_addr == eseq);
        fill = (TIMEOUT > 0) && load && !head_st && !byp && !in_vs && (occupancy != '0) && (to_cnt == 32'(TIMEOUT));
        emit = load && (head_st || byp || fill);
        store = in_valid && win && !hit && !byp;
        flags_nxt = flags_eff;
        if (load && head_st) flags_nxt[head] = 1'b0;
        if (store) flags_nxt[slot] = 1'b1;
        pop = '0;
        for (int i = 0; i < DEPTH; i++) pop = pop + OW'(flags_nxt[i]);
        to_nxt = (TIMEOUT == 0 || in_vs || emit || occupancy == '0) ? '0 : (load && !head_st) ? to_cnt + 32'd1 : to_cnt;
    end
    pixel_reorder_mem #(.DW(DW), .DEPTH(DEPTH)) u_mem (
        .clk  (clk),
        .we   (store),
        .waddr(slot),
        .wdata(in_data),
        .raddr(head),
        .rdata(head_data)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq <= '0;
            flags <= '0;
            occupancy <= '0;
            to_cnt <= '0;
            out_vs <= 1'b0;
            err_window <= 1'b0;
            err_dup <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_addr <= '0;
            out_skipped <= 1'b0;
        end else begin
            seq <= eseq + AW'(emit);
            flags <= flags_nxt;
            occupancy <= pop;
            to_cnt <= to_nxt;
            out_vs <= in_vs;
            err_window <= in_valid && !win;
            err_dup <= in_valid && win && hit;
            if (load) out_valid <= emit;
            if (emit) begin
                out_data <= head_st ? head_data : byp ? in_data : FILL;
                out_addr <= eseq;
                out_skipped <= fill;
            end
        end
    end
endmodule
